// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Shared types and sizes for the div16u8_seq sequential divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;
  localparam int DW         = 16;
  localparam int VW         = 8;
  localparam int ITER_EXACT = 16;
  localparam int CW         = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
  import div_pkg::*;
(
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_b,
  output logic [VW-1:0] o_rem,
  output logic          o_q
);

  logic [VW:0] w_rem9;
  logic [VW:0] w_diff;

  // rem < B keeps rem9 < 2*B, so bit VW of the difference is exactly the borrow
  always_comb begin
    w_rem9 = {i_rem, i_bit};
    w_diff = w_rem9 - {1'b0, i_b};
    o_q    = ~w_diff[VW];
    o_rem  = o_q ? w_diff[VW-1:0] : w_rem9[VW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/div16u8_seq.sv
// ============================================================================
// Module : div16u8_seq
// Sequential restoring 16/8 unsigned divider with valid/ready handshakes.
// Build macro DIV_APPROX_EN skips the APPROX_DROP lowest quotient iterations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div16u8_seq
  import div_pkg::*;
#(
  parameter int APPROX_DROP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          DZ
);

`ifdef DIV_APPROX_EN
  localparam int c_drop = APPROX_DROP;
`else
  localparam int c_drop = APPROX_DROP * 0;
`endif
  localparam int c_iter = ITER_EXACT - c_drop;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dividend;
  logic [DW-1:0] r_quo;
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_b;
  logic [VW-1:0] w_rem_next;
  logic          w_qbit;
  logic [DW-1:0] w_quo_next;

  div_step u_step (
    .i_rem (r_rem),
    .i_bit (r_dividend[DW-1]),
    .i_b   (r_b),
    .o_rem (w_rem_next),
    .o_q   (w_qbit)
  );

  assign w_quo_next = {r_quo[DW-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = (B == '0) ? DONE : BUSY;
      BUSY:    if (r_cnt == CW'(1)) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Result registers are written only on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_b        <= '0;
      Q          <= '0;
      R          <= '0;
      DZ         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dividend <= A;
            r_b        <= B;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= CW'(c_iter);
            if (B == '0) begin
              Q  <= '1;
              R  <= A[VW-1:0];
              DZ <= 1'b1;
            end
          end
        end
        BUSY: begin
          r_dividend <= {r_dividend[DW-2:0], 1'b0};
          r_rem      <= w_rem_next;
          r_quo      <= w_quo_next;
          r_cnt      <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
`ifdef DIV_APPROX_EN
            Q <= w_quo_next << c_drop;
            R <= '0;
`else
            Q <= w_quo_next;
            R <= w_rem_next;
`endif
            DZ <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div16u8_seq.sv
// ============================================================================
// Module : tb_div16u8_seq
// Self-checking bench for div16u8_seq with a result/latency scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div16u8_seq;

  localparam int D = 2;
`ifdef DIV_APPROX_EN
  localparam int ITER = 16 - D;
`else
  localparam int ITER = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        DZ;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic [31:0] t0;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic ov_d = 1'b0;

  div16u8_seq #(.APPROX_DROP(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .DZ        (DZ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int t0);
    exp_t e;
    int   ai;
    int   bi;
    ai   = int'(a);
    bi   = int'(b);
    e.t0 = t0;
    if (bi == 0) begin
      e.q  = 16'hFFFF;
      e.r  = a[7:0];
      e.dz = 1'b1;
    end else begin
`ifdef DIV_APPROX_EN
      e.q = 16'(((ai >> D) / bi) << D);
      e.r = 8'd0;
`else
      e.q = 16'(ai / bi);
      e.r = 8'(ai % bi);
`endif
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Accepts push expectations; output handshakes pop and compare
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ov_d <= 1'b0;
    end else begin
      if (in_valid && in_ready) sb.push_back(model(A, B, cyc));
      if (out_valid && !ov_d) begin
        if (sb.size() == 0) chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        else chk("latency", cyc - sb[0].t0, sb[0].dz ? 1 : ITER + 1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_result", {31'd0, out_valid}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("Q", {16'd0, Q}, {16'd0, e.q});
          chk("R", {24'd0, R}, {24'd0, e.r});
          chk("DZ", {31'd0, DZ}, {31'd0, e.dz});
        end
      end
      ov_d <= out_valid;
    end
  end

  task automatic send(input logic [15:0] a, input logic [7:0] b, input bit hold_valid);
    int n = 0;
    A = a;
    B = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_Q"}, {16'd0, Q}, 32'd0);
    chk({tag, "_R"}, {24'd0, R}, 32'd0);
    chk({tag, "_DZ"}, {31'd0, DZ}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_h;
    int   n;

    #12;
    chk_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(16'd1000, 8'd7, 1'b0);   wait_idle();
    send(16'd65535, 8'd255, 1'b0); wait_idle();
    send(16'd5, 8'd9, 1'b0);      wait_idle();
    send(16'd0, 8'd1, 1'b0);      wait_idle();
    send(16'd100, 8'd0, 1'b0);    wait_idle();

    // Consumer stalls for 10 cycles after the result appears
    out_ready = 1'b0;
    send(16'd40000, 8'd200, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    e_h = model(16'd40000, 8'd200, 0);
    repeat (10) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_Q", {16'd0, Q}, {16'd0, e_h.q});
      chk("hold_R", {24'd0, R}, {24'd0, e_h.r});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);

    // Abort in the 8th BUSY cycle
    send(16'd1234, 8'd17, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midop_reset");
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(16'd1234, 8'd17, 1'b0);
    wait_idle();

    // Back-to-back random traffic with in_valid held high
    for (int i = 0; i < 2000; i++) begin
      send(16'($urandom), 8'($urandom_range(255, 1)), 1'b1);
    end
    in_valid = 1'b0;
    wait_idle();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
